mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage between the execute stage and writeback.
- Consumes the execute-stage ALU result as a data address or pass-through result, and the register B value as store data.
- Performs loads and stores over a req/ack data-memory handshake, handling byte/half/word lane alignment, sign/zero extension and a bounded wait.
- Holds the MEM/WB pipeline register and drives a stall back to the upstream stages.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in BUSY without ack before forced completion with error; legal range 1..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_mem_valid_inst  input  1  instruction in this stage is valid
ex_mem_alu_result  input  32  ALU result / effective address
ex_mem_regb  input  32  store data
ex_mem_rd_mem  input  1  load
ex_mem_wr_mem  input  1  store
ex_mem_funct3  input  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load
ex_mem_dest_reg_idx  input  5  destination register
Dmem2proc_ack  input  1  memory completes current request
Dmem2proc_rdata  input  32  read data, valid with ack
proc2Dmem_req  output  1  request active
proc2Dmem_we  output  1  store
proc2Dmem_addr  output  32  word address (bits [1:0] = 0)
proc2Dmem_wdata  output  32  lane-replicated store data
proc2Dmem_be  output  4  byte enables
mem_stall_out  output  1  hold upstream stages
mem_wb_valid  output  1  registered: valid instruction
mem_wb_result  output  32  registered: load data or pass-through ALU result
mem_wb_dest_reg_idx  output  5  registered destination
mem_wb_err  output  1  registered: access timed out
mem_wb_misaligned  output  1  registered: misaligned trap (0 when feature off)

Behaviour:
- Clock: one clock; reset is synchronous, active-high.
- Reset: state IDLE; timeout counter 0; all registered outputs 0; proc2Dmem_req 0.
- Reset mid-transaction abandons the access: req is low the cycle after the reset edge, and no writeback occurs.
- A mem op is ex_mem_valid_inst & (rd_mem | wr_mem). If both rd_mem and wr_mem are set, the op is a store.
- FSM states:
  - IDLE -> BUSY when a mem op is present (and it is not trapped).
  - BUSY -> IDLE on ack, or when the counter reaches TIMEOUT_CYCLES-1 without ack.
- proc2Dmem_* are registered:
  - Latched on the IDLE->BUSY edge and held constant through BUSY.
  - req = 1 only in BUSY.
- mem_stall_out (combinational) = mem op present & !(state==BUSY & (ack | timeout)).
  - Non-mem ops never stall.
  - Upstream holds its inputs stable while stalled.
- Latency:
  - Non-mem op at cycle t: MEM/WB registers update at edge t+1.
  - Load/store entering at t: req high from t+1; ack at t+k gives writeback at t+k+1.
  - Minimum mem-op occupancy is 2 cycles.
- MEM/WB register updates every cycle stall is low:
  - valid = ex_mem_valid_inst.
  - Invalid input produces valid=0 and result 0.
  - While stalled, mem_wb_valid = 0 (bubble).
- Store:
  - wdata: byte replicated ×4, half ×2, word as-is.
  - be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
  - Store writeback: valid=1, result = ALU result, dest as given.
- Load extraction uses the latched addr[1:0]:
  - Select byte / half lane from rdata.
  - Sign-extend when funct3[2]=0, else zero-extend; word is as-is.
- Timeout:
  - Counter increments each BUSY cycle without ack.
  - On timeout completion: result 0, mem_wb_err=1, req drops next cycle.
  - Ack arriving in IDLE is ignored.
  - Ack and timeout in the same cycle count as ack (err=0).
- Address bits [1:0] are never driven to memory.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 is trapped.
  - No request is issued and stall stays 0.
  - Next edge: mem_wb_valid=1, mem_wb_misaligned=1, result 0.
  - Stores are suppressed.
- Undefined: offset is truncated to natural alignment (half clears bit 0, word clears [1:0]); mem_wb_misaligned is tied 0.

Test Plan:
1. Reset asserted during BUSY with req=1 -> req=0 and all mem_wb_* = 0 after that edge; later ack ignored, no writeback.
2. Non-mem op, ALU result 0x0000_1234, dest 5 -> no stall; next edge mem_wb_valid=1, result 0x1234, dest 5.
3. LB at addr 0x103, ack after 3 cycles with rdata 0x80FF_0000 -> stall for 4 cycles, be latched 1000, req addr 0x100; writeback result 0xFFFF_FF80.
   - Repeat as LBU -> result 0x0000_0080.
4. SH at addr 0x22, regb 0xDEAD_BEEF -> we=1, addr 0x20, wdata 0xBEEF_BEEF, be 1100; ack -> mem_wb_valid=1, err=0.
5. LW with no ack, TIMEOUT_CYCLES=4 -> req high 4 cycles, stall drops on the 4th; writeback result 0, err=1; then IDLE.
6. LW at 0x102:
   - With MEM_MISALIGN_TRAP_EN: no req; next edge misaligned=1, valid=1.
   - Without: req addr 0x100, normal load.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: drives the data-memory req/ack handshake and holds the MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_rd_mem,
  input  logic        ex_mem_wr_mem,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [4:0]  ex_mem_dest_reg_idx,
  input  logic        Dmem2proc_ack,
  input  logic [31:0] Dmem2proc_rdata,
  output logic        proc2Dmem_req,
  output logic        proc2Dmem_we,
  output logic [31:0] proc2Dmem_addr,
  output logic [31:0] proc2Dmem_wdata,
  output logic [3:0]  proc2Dmem_be,
  output logic        mem_stall_out,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_dest_reg_idx,
  output logic        mem_wb_err,
  output logic        mem_wb_misaligned
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic        wb_err_q, wb_err_d;
  logic        wb_mis_q, wb_mis_d;

  logic        mem_op, trap, done, stall;
  logic [1:0]  size, eff_off;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign mem_op = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
  assign size   = ex_mem_funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & (((size == 2'b01) & ex_mem_alu_result[0]) |
                          (size[1] & (ex_mem_alu_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Completion is ack or the last allowed BUSY cycle; ack wins when both coincide.
  assign done  = (state_q == BUSY) & (Dmem2proc_ack | (cnt_q == CNT_LAST));
  assign stall = mem_op & ~trap & ~done;

  always_comb begin
    eff_off  = 2'b00;
    st_wdata = ex_mem_regb;
    st_be    = 4'b1111;
    case (size)
      2'b00: begin
        eff_off  = ex_mem_alu_result[1:0];
        st_wdata = {4{ex_mem_regb[7:0]}};
        st_be    = 4'b0001 << eff_off;
      end
      2'b01: begin
        eff_off  = {ex_mem_alu_result[1], 1'b0};
        st_wdata = {2{ex_mem_regb[15:0]}};
        st_be    = 4'b0011 << eff_off;
      end
      default: begin
        eff_off  = 2'b00;
        st_wdata = ex_mem_regb;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = Dmem2proc_rdata[7:0];
    case (off_q)
      2'd0:    ld_byte = Dmem2proc_rdata[7:0];
      2'd1:    ld_byte = Dmem2proc_rdata[15:8];
      2'd2:    ld_byte = Dmem2proc_rdata[23:16];
      default: ld_byte = Dmem2proc_rdata[31:24];
    endcase
    ld_half = off_q[1] ? Dmem2proc_rdata[31:16] : Dmem2proc_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = Dmem2proc_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (mem_op && !trap) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = ex_mem_wr_mem;
          addr_d  = {ex_mem_alu_result[31:2], 2'b00};
          wdata_d = st_wdata;
          be_d    = st_be;
          off_d   = eff_off;
          f3_d    = ex_mem_funct3;
        end
      end
      default: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // Stalled cycles write a bubble; otherwise the register follows the incoming instruction.
  always_comb begin
    wb_valid_d  = 1'b0;
    wb_result_d = '0;
    wb_dest_d   = '0;
    wb_err_d    = 1'b0;
    wb_mis_d    = 1'b0;
    if (!stall && ex_mem_valid_inst) begin
      wb_valid_d = 1'b1;
      wb_dest_d  = ex_mem_dest_reg_idx;
      if (trap) begin
        wb_mis_d = 1'b1;
      end else if (mem_op) begin
        if (Dmem2proc_ack) begin
          wb_result_d = ex_mem_wr_mem ? ex_mem_alu_result : ld_data;
        end else begin
          wb_err_d = 1'b1;
        end
      end else begin
        wb_result_d = ex_mem_alu_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_dest_q   <= '0;
      wb_err_q    <= 1'b0;
      wb_mis_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_dest_q   <= wb_dest_d;
      wb_err_q    <= wb_err_d;
      wb_mis_q    <= wb_mis_d;
    end
  end

  assign proc2Dmem_req       = req_q;
  assign proc2Dmem_we        = we_q;
  assign proc2Dmem_addr      = addr_q;
  assign proc2Dmem_wdata     = wdata_q;
  assign proc2Dmem_be        = be_q;
  assign mem_stall_out       = stall;
  assign mem_wb_valid        = wb_valid_q;
  assign mem_wb_result       = wb_result_q;
  assign mem_wb_dest_reg_idx = wb_dest_q;
  assign mem_wb_err          = wb_err_q;
  assign mem_wb_misaligned   = wb_mis_q;

endmodule
